psum_accumulator: RTL

- Read-modify-write front end for the partial-sum scratchpad.
- Accepts a stream of signed products tagged with a scratch address and first/last flags.
- Reads the stored partial sum, adds the product with saturation and writes the result back.
- On the last term of an address, also pushes the final sum to a downstream output port. It sits between the PE multiplier output and the scratch, driving all scratch ports.

---
 rtl/psum_accumulator.sv | 119 +++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator: read-modify-write partial-sum front end with saturation and a 2-entry result FIFO
module psum_accumulator #(
  parameter int ADDR_LEN   = 8,
  parameter int PROD_WIDTH = 16,
  parameter int PSUM_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_LEN-1:0]   in_addr,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  sp_wen,
  output logic [ADDR_LEN-1:0]   sp_waddr,
  output logic [PSUM_WIDTH-1:0] sp_din,
  output logic [ADDR_LEN-1:0]   sp_raddr,
  input  logic [PSUM_WIDTH-1:0] sp_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_data,
  output logic [ADDR_LEN-1:0]   out_addr,
  output logic                  sat_flag
);
  localparam int S = PSUM_WIDTH;
  localparam int P = PROD_WIDTH;

  logic                s1_valid, s1_first, s1_last;
  logic [ADDR_LEN-1:0] s1_addr;
  logic [P-1:0]        s1_data;
  logic                wb_valid;
  logic [ADDR_LEN-1:0] wb_addr;
  logic [S-1:0]        wb_sum;
  logic [S-1:0]        f_data [2];
  logic [ADDR_LEN-1:0] f_addr [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;
  logic [S-1:0]        operand, sum;
  logic [S:0]          raw;
  logic                ovf, accept, push, pop;

  assign accept    = in_valid && in_ready;
  assign push      = s1_valid && s1_last;
  assign pop       = out_valid && out_ready;
  assign in_ready  = rst && (({1'b0, count} + {2'b0, push}) < 3'd2);
  assign sp_raddr  = in_addr;
  assign sp_wen    = s1_valid;
  assign sp_waddr  = s1_addr;
  assign sp_din    = sum;
  assign out_valid = count != 2'd0;
  assign out_data  = f_data[rd_ptr];
  assign out_addr  = f_addr[rd_ptr];

  // operand select (forward the write still landing this edge), widened add, clamp on overflow
  always_comb begin
    operand = s1_first ? '0 : (wb_valid && wb_addr == s1_addr) ? wb_sum : sp_dout;
    raw     = {operand[S-1], operand} + {{(S+1-P){s1_data[P-1]}}, s1_data};
    ovf     = raw[S] != raw[S-1];
    sum     = !ovf ? raw[S-1:0] : raw[S] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}};
  end

  // S1: capture the accepted op alongside the scratch read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_addr  <= in_addr;
        s1_data  <= in_data;
      end
    end
  end

  // WB: remember what is being written so the next op can forward it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_sum   <= '0;
    end else begin
      wb_valid <= s1_valid;
      wb_addr  <= s1_addr;
      wb_sum   <= sum;
    end
  end

  // output FIFO of final sums; in_ready guarantees room for every push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_data <= '{default: '0};
      f_addr <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        f_data[wr_ptr] <= sum;
        f_addr[wr_ptr] <= s1_addr;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // sticky saturation indicator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_flag <= 1'b0;
    else if (s1_valid && ovf) sat_flag <= 1'b1;
  end
endmodule
